// File: rtl/pipelined_cond_control_unit.sv
// Pipelined control unit: decodes in D, carries controls through ID/EX and EX/MEM
// registers, and gates writes in E with ARM condition codes against the NZCV register.
module pipelined_cond_control_unit #(
    parameter int         ALUCTRL_W = 3,
    parameter bit         EXT_ALU   = 1'b1,
    parameter logic [3:0] PC_REG    = 4'd15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           OpD,
    input  logic [5:0]           FunctD,
    input  logic [3:0]           CondD,
    input  logic [3:0]           RdD,
    input  logic [3:0]           ALUFlags,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic [1:0]           RegSrcD,
    output logic [1:0]           ImmSrcD,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 MemtoRegM,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 PCSrcM,
    output logic                 BranchTakenE,
    output logic                 CondExE,
    output logic                 IllegalE,
    output logic [3:0]           Flags
);

    typedef struct packed {
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       flags_write;
        logic       illegal;
        logic [3:0] cond;
        logic [3:0] rd;
    } ctrl_e_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_write;
        logic pc_src;
    } ctrl_m_t;

    // A bubble carries cond 1111, which never passes, so it can never write anything.
    localparam ctrl_e_t E_BUBBLE = '{cond: 4'b1111, default: '0};

    ctrl_e_t    dec_d, e_d, e_q;
    ctrl_m_t    m_d, m_q;
    logic [3:0] flags_d, flags_q;
    logic [1:0] reg_src_d, imm_src_d;
    logic [2:0] dp_alu;
    logic       dp_known, dp_compare;
    logic       cond_ex, pc_src_e;

    // Data-processing cmd decode; EOR/TST/CMN exist only with EXT_ALU.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        dp_alu     = 3'b000;
        dp_known   = 1'b1;
        dp_compare = 1'b0;
        unique case (FunctD[4:1])
            4'b0100: dp_alu = 3'b000;
            4'b0010: dp_alu = 3'b001;
            4'b0000: dp_alu = 3'b010;
            4'b1100: dp_alu = 3'b011;
            4'b1101: dp_alu = 3'b100;
            4'b1010: begin dp_alu = 3'b001; dp_compare = 1'b1; end
            4'b0001: begin dp_alu = 3'b101; dp_known = EXT_ALU; end
            4'b1000: begin dp_alu = 3'b010; dp_compare = 1'b1; dp_known = EXT_ALU; end
            4'b1011: begin dp_alu = 3'b000; dp_compare = 1'b1; dp_known = EXT_ALU; end
            default: dp_known = 1'b0;
        endcase
    end

    always_comb begin
        dec_d      = '0;
        dec_d.cond = CondD;
        dec_d.rd   = RdD;
        reg_src_d  = 2'b00;
        imm_src_d  = 2'b00;
        unique case (OpD)
            2'b00: begin
                if (dp_known) begin
                    dec_d.alu_src     = FunctD[5];
                    dec_d.alu_ctrl    = dp_alu;
                    dec_d.reg_write   = !dp_compare;
                    dec_d.flags_write = FunctD[0] | dp_compare;
                end else begin
                    dec_d.illegal = 1'b1;
                end
            end
            2'b01: begin
                dec_d.alu_src = 1'b1;
                imm_src_d     = 2'b01;
                if (FunctD[0]) begin
                    dec_d.mem_to_reg = 1'b1;
                    dec_d.reg_write  = 1'b1;
                end else begin
                    reg_src_d       = 2'b10;
                    dec_d.mem_write = 1'b1;
                end
            end
            2'b10: begin
                reg_src_d      = 2'b01;
                imm_src_d      = 2'b10;
                dec_d.alu_src  = 1'b1;
                dec_d.branch   = 1'b1;
            end
            default: dec_d.illegal = 1'b1;
        endcase
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        unique case (e_q.cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = !z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = !c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = !n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = !v;
            4'b1000: cond_ex = c & !z;
            4'b1001: cond_ex = !c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = !z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign pc_src_e = cond_ex & (e_q.branch | (e_q.reg_write & (e_q.rd == PC_REG)));

    always_comb begin
        e_d = e_q;
        if (FlushE)
            e_d = E_BUBBLE;
        else if (!StallE)
            e_d = dec_d;

        m_d = '0;
        if (!StallE)
            m_d = '{mem_to_reg: e_q.mem_to_reg,
                    reg_write:  e_q.reg_write & cond_ex,
                    mem_write:  e_q.mem_write & cond_ex,
                    pc_src:     pc_src_e};

        flags_d = flags_q;
        if (e_q.flags_write && cond_ex && !StallE)
            flags_d = ALUFlags;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q     <= E_BUBBLE;
            m_q     <= '0;
            flags_q <= '0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            flags_q <= flags_d;
        end
    end

    assign RegSrcD      = reg_src_d;
    assign ImmSrcD      = imm_src_d;
    assign ALUSrcE      = e_q.alu_src;
    assign ALUControlE  = ALUCTRL_W'(e_q.alu_ctrl);
    assign BranchTakenE = e_q.branch & cond_ex;
    assign CondExE      = cond_ex;
    assign IllegalE     = e_q.illegal;
    assign MemtoRegM    = m_q.mem_to_reg;
    assign RegWriteM    = m_q.reg_write;
    assign MemWriteM    = m_q.mem_write;
    assign PCSrcM       = m_q.pc_src;
    assign Flags        = flags_q;

endmodule

// File: tb/tb_pipelined_cond_control_unit.sv
// Scoreboard bench: stimulus queues expected values tagged with the cycle they
// must appear in; a negedge monitor pops and compares them.
module tb_pipelined_cond_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] OpD;
    logic [5:0] FunctD;
    logic [3:0] CondD, RdD, ALUFlags;
    logic       StallE, FlushE;

    logic [1:0] RegSrcD, ImmSrcD;
    logic       ALUSrcE, MemtoRegM, RegWriteM, MemWriteM, PCSrcM;
    logic       BranchTakenE, CondExE, IllegalE;
    logic [2:0] ALUControlE;
    logic [3:0] Flags;

    logic [1:0] RegSrcD_x, ImmSrcD_x;
    logic       ALUSrcE_x, MemtoRegM_x, RegWriteM_x, MemWriteM_x, PCSrcM_x;
    logic       BranchTakenE_x, CondExE_x, IllegalE_x;
    logic [3:0] ALUControlE_x;
    logic [3:0] Flags_x;

    always #5 clk = ~clk;

    pipelined_cond_control_unit #(.ALUCTRL_W(3), .EXT_ALU(1'b1), .PC_REG(4'd15)) dut (
        .clk(clk), .rst_n(rst_n), .OpD(OpD), .FunctD(FunctD), .CondD(CondD), .RdD(RdD),
        .ALUFlags(ALUFlags), .StallE(StallE), .FlushE(FlushE),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .PCSrcM(PCSrcM),
        .BranchTakenE(BranchTakenE), .CondExE(CondExE), .IllegalE(IllegalE), .Flags(Flags)
    );

    pipelined_cond_control_unit #(.ALUCTRL_W(4), .EXT_ALU(1'b0), .PC_REG(4'd15)) dut_noext (
        .clk(clk), .rst_n(rst_n), .OpD(OpD), .FunctD(FunctD), .CondD(CondD), .RdD(RdD),
        .ALUFlags(ALUFlags), .StallE(StallE), .FlushE(FlushE),
        .RegSrcD(RegSrcD_x), .ImmSrcD(ImmSrcD_x), .ALUSrcE(ALUSrcE_x), .ALUControlE(ALUControlE_x),
        .MemtoRegM(MemtoRegM_x), .RegWriteM(RegWriteM_x), .MemWriteM(MemWriteM_x), .PCSrcM(PCSrcM_x),
        .BranchTakenE(BranchTakenE_x), .CondExE(CondExE_x), .IllegalE(IllegalE_x), .Flags(Flags_x)
    );

    typedef enum {
        S_REGSRC, S_IMMSRC, S_ALUSRC, S_ALUCTL, S_MEMTOREG, S_REGWRITE, S_MEMWRITE,
        S_PCSRC, S_BRTAKEN, S_CONDEX, S_ILLEGAL, S_FLAGS, S_ILLEGAL_X, S_REGWRITE_X, S_ALUCTL_X
    } sel_t;

    typedef struct {
        int         cyc;
        sel_t       sel;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(sel_t s);
        case (s)
            S_REGSRC:     return {6'd0, RegSrcD};
            S_IMMSRC:     return {6'd0, ImmSrcD};
            S_ALUSRC:     return {7'd0, ALUSrcE};
            S_ALUCTL:     return {5'd0, ALUControlE};
            S_MEMTOREG:   return {7'd0, MemtoRegM};
            S_REGWRITE:   return {7'd0, RegWriteM};
            S_MEMWRITE:   return {7'd0, MemWriteM};
            S_PCSRC:      return {7'd0, PCSrcM};
            S_BRTAKEN:    return {7'd0, BranchTakenE};
            S_CONDEX:     return {7'd0, CondExE};
            S_ILLEGAL:    return {7'd0, IllegalE};
            S_FLAGS:      return {4'd0, Flags};
            S_ILLEGAL_X:  return {7'd0, IllegalE_x};
            S_REGWRITE_X: return {7'd0, RegWriteM_x};
            S_ALUCTL_X:   return {4'd0, ALUControlE_x};
            default:      return 8'hee;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic sb_push(input int ofs, input sel_t s, input logic [7:0] v, input string name);
        exp_t e;
        e.cyc  = cyc + ofs;
        e.sel  = s;
        e.val  = v;
        e.name = name;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                check(sb_q[i].name, actual(sb_q[i].sel), sb_q[i].val);
                sb_q.delete(i);
            end
        end
    end

    // flags_e is the ALUFlags value for the instruction currently sitting in E.
    task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] cond,
                         input logic [3:0] rd, input logic [3:0] flags_e,
                         input logic stall, input logic flush);
        @(posedge clk);
        #1;
        OpD      = op;
        FunctD   = funct;
        CondD    = cond;
        RdD      = rd;
        ALUFlags = flags_e;
        StallE   = stall;
        FlushE   = flush;
    endtask

    task automatic nop();
        drive(2'b00, 6'b000000, 4'b1111, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; OpD = '0; FunctD = '0; CondD = '0; RdD = '0;
        ALUFlags = '0; StallE = 1'b0; FlushE = 1'b0;

        // Reset state
        nop();
        nop();
        sb_push(0, S_FLAGS,    8'h0, "rst_flags");
        sb_push(0, S_CONDEX,   8'h0, "rst_condex");
        sb_push(0, S_ALUCTL,   8'h0, "rst_aluctl");
        sb_push(0, S_ALUSRC,   8'h0, "rst_alusrc");
        sb_push(0, S_ILLEGAL,  8'h0, "rst_illegal");
        sb_push(0, S_BRTAKEN,  8'h0, "rst_brtaken");
        sb_push(0, S_REGWRITE, 8'h0, "rst_regwrite");
        sb_push(0, S_MEMWRITE, 8'h0, "rst_memwrite");
        sb_push(0, S_MEMTOREG, 8'h0, "rst_memtoreg");
        sb_push(0, S_PCSRC,    8'h0, "rst_pcsrc");
        rst_n = 1'b1;

        // Idle inputs after release: AND/EQ with Z=0 never passes
        drive(2'b00, 6'b000000, 4'b0000, 4'd0, 4'd0, 1'b0, 1'b0);
        sb_push(1, S_CONDEX,   8'h0, "idle_condex");
        sb_push(2, S_REGWRITE, 8'h0, "idle_regwrite");

        // CMP #imm, AL; ALU reports Z
        drive(2'b00, 6'b110101, 4'b1110, 4'd0, 4'd0, 1'b0, 1'b0);
        sb_push(0, S_IMMSRC,   8'h0, "cmp_immsrc");
        sb_push(1, S_ALUSRC,   8'h1, "cmp_alusrc");
        sb_push(1, S_ALUCTL,   8'h1, "cmp_aluctl");
        sb_push(1, S_CONDEX,   8'h1, "cmp_condex_al");
        sb_push(2, S_FLAGS,    8'h4, "cmp_flags");
        sb_push(2, S_REGWRITE, 8'h0, "cmp_regwrite");

        // BEQ directly after the CMP
        drive(2'b10, 6'b000000, 4'b0000, 4'd0, 4'b0100, 1'b0, 1'b0);
        sb_push(0, S_REGSRC,  8'h1, "beq_regsrc");
        sb_push(0, S_IMMSRC,  8'h2, "beq_immsrc");
        sb_push(1, S_BRTAKEN, 8'h1, "beq_taken");
        sb_push(2, S_PCSRC,   8'h1, "beq_pcsrc_m");

        // ADDS NE while Z=1: suppressed, flags untouched
        drive(2'b00, 6'b001001, 4'b0001, 4'd3, 4'd0, 1'b0, 1'b0);
        sb_push(1, S_CONDEX,   8'h0, "addne_condex");
        sb_push(2, S_REGWRITE, 8'h0, "addne_regwrite");
        sb_push(2, S_FLAGS,    8'h4, "addne_flags_hold");

        // LDR to R15
        drive(2'b01, 6'b011001, 4'b1110, 4'd15, 4'b0011, 1'b0, 1'b0);
        sb_push(0, S_IMMSRC,   8'h1, "ldr_immsrc");
        sb_push(1, S_ALUSRC,   8'h1, "ldr_alusrc");
        sb_push(1, S_ALUCTL,   8'h0, "ldr_aluctl");
        sb_push(2, S_PCSRC,    8'h1, "ldr_pcsrc");
        sb_push(2, S_MEMTOREG, 8'h1, "ldr_memtoreg");
        sb_push(2, S_REGWRITE, 8'h1, "ldr_regwrite");
        sb_push(2, S_MEMWRITE, 8'h0, "ldr_memwrite");

        // STR
        drive(2'b01, 6'b011000, 4'b1110, 4'd2, 4'd0, 1'b0, 1'b0);
        sb_push(0, S_REGSRC,   8'h2, "str_regsrc");
        sb_push(0, S_IMMSRC,   8'h1, "str_immsrc");
        sb_push(2, S_MEMWRITE, 8'h1, "str_memwrite");
        sb_push(2, S_REGWRITE, 8'h0, "str_regwrite");
        sb_push(2, S_PCSRC,    8'h0, "str_pcsrc");

        // CMP giving N=1,V=0, then MOVLT (passes) and MOVGE (fails)
        drive(2'b00, 6'b110101, 4'b1110, 4'd0, 4'd0, 1'b0, 1'b0);
        sb_push(2, S_FLAGS, 8'h8, "cmp2_flags");
        drive(2'b00, 6'b011010, 4'b1011, 4'd6, 4'b1000, 1'b0, 1'b0);
        sb_push(1, S_ALUCTL,   8'h4, "movlt_aluctl");
        sb_push(1, S_CONDEX,   8'h1, "movlt_condex");
        sb_push(2, S_REGWRITE, 8'h1, "movlt_regwrite");
        drive(2'b00, 6'b011010, 4'b1010, 4'd7, 4'd0, 1'b0, 1'b0);
        sb_push(1, S_CONDEX,   8'h0, "movge_condex");
        sb_push(2, S_REGWRITE, 8'h0, "movge_regwrite");

        // ORR held in E for two stalled cycles
        drive(2'b00, 6'b011000, 4'b1110, 4'd4, 4'd0, 1'b0, 1'b0);
        sb_push(1, S_ALUCTL,   8'h3, "orr_aluctl");
        sb_push(2, S_ALUCTL,   8'h3, "stall1_aluctl");
        sb_push(2, S_REGWRITE, 8'h0, "stall1_m_bubble");
        sb_push(3, S_ALUCTL,   8'h3, "stall2_aluctl");
        sb_push(3, S_REGWRITE, 8'h0, "stall2_m_bubble");
        sb_push(4, S_REGWRITE, 8'h1, "orr_after_stall_regwrite");
        sb_push(4, S_ALUCTL,   8'h0, "add_after_stall_aluctl");
        drive(2'b00, 6'b001000, 4'b1110, 4'd5, 4'd0, 1'b1, 1'b0);
        drive(2'b00, 6'b001000, 4'b1110, 4'd5, 4'd0, 1'b1, 1'b0);
        drive(2'b00, 6'b001000, 4'b1110, 4'd5, 4'd0, 1'b0, 1'b0);

        // Flush together with stall wins
        drive(2'b00, 6'b011000, 4'b1110, 4'd5, 4'd0, 1'b1, 1'b1);
        sb_push(1, S_ALUCTL,   8'h0, "flush_aluctl");
        sb_push(1, S_CONDEX,   8'h0, "flush_condex");
        sb_push(1, S_REGWRITE, 8'h0, "flush_m_bubble");

        // Op=11 illegal, Rd=15 must not redirect
        drive(2'b11, 6'b000000, 4'b1110, 4'd15, 4'd0, 1'b0, 1'b0);
        sb_push(0, S_REGSRC,   8'h0, "ill_regsrc");
        sb_push(0, S_IMMSRC,   8'h0, "ill_immsrc");
        sb_push(1, S_ILLEGAL,  8'h1, "ill_illegal");
        sb_push(1, S_BRTAKEN,  8'h0, "ill_brtaken");
        sb_push(2, S_REGWRITE, 8'h0, "ill_regwrite");
        sb_push(2, S_MEMWRITE, 8'h0, "ill_memwrite");
        sb_push(2, S_PCSRC,    8'h0, "ill_pcsrc");

        // EOR: legal with EXT_ALU=1, illegal with EXT_ALU=0
        drive(2'b00, 6'b000010, 4'b1110, 4'd1, 4'd0, 1'b0, 1'b0);
        sb_push(1, S_ALUCTL,     8'h5, "eor_aluctl");
        sb_push(1, S_ILLEGAL,    8'h0, "eor_illegal");
        sb_push(1, S_ILLEGAL_X,  8'h1, "eor_noext_illegal");
        sb_push(1, S_ALUCTL_X,   8'h0, "eor_noext_aluctl");
        sb_push(2, S_REGWRITE,   8'h1, "eor_regwrite");
        sb_push(2, S_REGWRITE_X, 8'h0, "eor_noext_regwrite");

        // Reset mid-stream discards the ADD in E and clears Flags
        drive(2'b00, 6'b001000, 4'b1110, 4'd1, 4'd0, 1'b0, 1'b0);
        nop();
        sb_push(0, S_FLAGS, 8'h8, "pre_reset_flags");
        rst_n = 1'b0;
        nop();
        rst_n = 1'b1;
        sb_push(0, S_FLAGS,    8'h0, "midrst_flags");
        sb_push(0, S_REGWRITE, 8'h0, "midrst_regwrite");
        sb_push(0, S_CONDEX,   8'h0, "midrst_condex");
        sb_push(0, S_ALUCTL,   8'h0, "midrst_aluctl");

        repeat (4) nop();
        @(posedge clk);
        #1;
        foreach (sb_q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: never sampled (due cycle %0d)", sb_q[i].name, sb_q[i].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
